// File: rtl/timer_bus_regs.sv
// timer_bus_regs: CPU bus register window (TH/TL/TCON/OVR) and handshaked overflow interrupt for the interval timer.
// Define TIMER_OVR_CNT_EN to add the saturating overrun counter at offset 3.
module timer_bus_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] TH_RST    = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [31:0] TH,
    output logic [1:0]  timer_CON,
    input  logic [31:0] TL,
    input  logic        timer_State,
    output logic        irq_req,
    input  logic        irq_ack,
    input  logic        irq_done
);
    typedef enum logic [1:0] {IDLE, PEND, SERV} st_t;

    st_t         st_q, st_d;
    logic [31:0] th_q, th_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        state_q;
    logic        wr_th, wr_tcon, evt;
    logic [31:0] ovr_rd;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, addr[1:0]};
    assign hit       = addr[31:4] == BASE_ADDR[31:4];
    assign wr_th     = mem_write && hit && addr[3:2] == 2'd0;
    assign wr_tcon   = mem_write && hit && addr[3:2] == 2'd2;
    assign evt       = timer_State && !state_q && tcon_q[1];
    assign th_d      = wr_th ? wdata : th_q;
    // A new event beats a simultaneous write-1-to-clear of status.
    assign tcon_d    = {evt || (tcon_q[2] && !(wr_tcon && wdata[2])), wr_tcon ? wdata[1:0] : tcon_q[1:0]};
    assign TH        = th_q;
    assign timer_CON = tcon_q[1:0];

`ifdef TIMER_OVR_CNT_EN
    logic [7:0] ovr_q, ovr_d;
    assign ovr_d  = (mem_write && hit && addr[3:2] == 2'd3) ? 8'd0
                  : (evt && st_q == SERV && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
    assign ovr_rd = {24'd0, ovr_q};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= 8'd0;
        else        ovr_q <= ovr_d;
    end
`else
    assign ovr_rd = 32'd0;
`endif

    always_comb begin
        rdata = !(mem_read && hit) ? 32'd0
              : addr[3:2] == 2'd0  ? th_q
              : addr[3:2] == 2'd1  ? TL
              : addr[3:2] == 2'd2  ? {29'd0, tcon_q} : ovr_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            th_q    <= TH_RST;
            tcon_q  <= 3'd0;
            state_q <= 1'b1;
        end else begin
            st_q    <= st_d;
            th_q    <= th_d;
            tcon_q  <= tcon_d;
            state_q <= timer_State;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = evt ? PEND : IDLE;
            PEND:    st_d = !tcon_d[1] ? IDLE : irq_ack ? SERV : PEND;
            SERV:    st_d = irq_done ? IDLE : SERV;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req = st_q == PEND;
    end
endmodule

// File: tb/tb_timer_bus_regs.sv
// tb_timer_bus_regs: directed stimulus with a queue-based scoreboard checked by a separate negedge monitor.
module tb_timer_bus_regs;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, TL = 32'h1234_5678;
    logic        timer_State = 1'b0, irq_ack = 1'b0, irq_done = 1'b0;
    logic [31:0] rdata, TH;
    logic [1:0]  timer_CON;
    logic        hit, irq_req;

    timer_bus_regs dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .TH(TH),
        .timer_CON(timer_CON), .TL(TL), .timer_State(timer_State),
        .irq_req(irq_req), .irq_ack(irq_ack), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    typedef struct {int sel; logic [31:0] exp;} exp_t;
    exp_t  q[$];
    string nq[$];
    int    n_chk = 0, n_fail = 0;

    // sel: 0 rdata, 1 TH, 2 timer_CON, 3 irq_req, 4 hit
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [31:0] got;
            e   = q.pop_front();
            nm  = nq.pop_front();
            got = e.sel == 0 ? rdata : e.sel == 1 ? TH : e.sel == 2 ? {30'd0, timer_CON}
                : e.sel == 3 ? {31'd0, irq_req} : {31'd0, hit};
            n_chk++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", nm, got, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int sel, input logic [31:0] exp, input string nm);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        cyc();
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        mem_read = 1'b1;
        addr     = a;
        expect_v(0, exp, nm);
        cyc();
        mem_read = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        expect_v(3, {31'd0, exp}, nm);
        cyc();
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        cyc();
        irq_done = 1'b0;
    endtask

    task automatic rise();
        timer_State = 1'b0;
        cyc();
        timer_State = 1'b1;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        expect_v(1, 32'h0001_0000, "rst_TH");
        expect_v(2, 32'd0, "rst_CON");
        expect_v(3, 32'd0, "rst_irq");
        expect_v(0, 32'd0, "rst_rdata");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        // register access and decode
        wr(32'h4000_0000, 32'hFFFF_FFF0);
        wr(32'h4000_0008, 32'h3);
        expect_v(1, 32'hFFFF_FFF0, "TH_write");
        expect_v(2, 32'h3, "CON_write");
        cyc();
        rd(32'h4000_0008, 32'h3, "TCON_read");
        rd(32'h4000_0004, 32'h1234_5678, "TL_read");
        wr(32'h4000_0004, 32'hDEAD_BEEF);
        TL = 32'h0BAD_F00D;
        rd(32'h4000_0004, 32'h0BAD_F00D, "TL_ro");
        wr(32'h4000_0003, 32'h0000_ABCD);
        rd(32'h4000_0001, 32'h0000_ABCD, "TH_byteoff");
        rd(32'h5000_0000, 32'd0, "miss_read");
        addr = 32'h4000_000C;
        expect_v(4, 32'd1, "hit_top");
        cyc();
        addr = 32'h3FFF_FFF0;
        expect_v(4, 32'd0, "hit_miss");
        expect_v(0, 32'd0, "noread_rdata");
        cyc();
        // interrupt handshake
        timer_State = 1'b1;
        chk_irq(1'b0, "irq_same_cycle");
        expect_v(3, 32'd1, "irq_asserted");
        rd(32'h4000_0008, 32'h7, "TCON_status");
        pulse_ack();
        chk_irq(1'b0, "irq_after_ack");
        rise();
        chk_irq(1'b0, "serv_event_not_req");
        rd(32'h4000_0008, 32'h7, "serv_status");
        pulse_done();
        chk_irq(1'b0, "serv_event_not_queued");
        wr(32'h4000_0008, 32'h7);
        rd(32'h4000_0008, 32'h3, "w1c_status");
        pulse_ack();
        pulse_done();
        chk_irq(1'b0, "ack_done_ignored_idle");
        rise();
        chk_irq(1'b1, "irq_second");
        pulse_ack();
        pulse_done();
        chk_irq(1'b0, "back_to_idle");
        // event beats W1C, absorption in PEND, irq_en cleared in PEND
        timer_State = 1'b0;
        cyc();
        timer_State = 1'b1;
        wr(32'h4000_0008, 32'h7);
        expect_v(3, 32'd1, "w1c_evt_irq");
        rd(32'h4000_0008, 32'h7, "w1c_evt_status");
        rise();
        chk_irq(1'b1, "pend_absorb");
        wr(32'h4000_0008, 32'h1);
        chk_irq(1'b0, "pend_irq_en_off");
        rd(32'h4000_0008, 32'h5, "pend_status_kept");
        // event with irq_en=0
        wr(32'h4000_0008, 32'h5);
        rd(32'h4000_0008, 32'h1, "clr_irq_dis");
        rise();
        chk_irq(1'b0, "irq_dis_no_req");
        rd(32'h4000_0008, 32'h1, "irq_dis_no_status");
        // overrun counter window
        wr(32'h4000_0008, 32'h3);
        rise();
        pulse_ack();
        for (int i = 0; i < 3; i++) rise();
`ifdef TIMER_OVR_CNT_EN
        rd(32'h4000_000C, 32'd3, "ovr_three");
        for (int i = 0; i < 300; i++) rise();
        rd(32'h4000_000C, 32'hFF, "ovr_sat");
        wr(32'h4000_000C, 32'h1234);
        rd(32'h4000_000C, 32'd0, "ovr_clear");
`else
        rd(32'h4000_000C, 32'd0, "ovr_absent");
        wr(32'h4000_000C, 32'hFFFF_FFFF);
        rd(32'h4000_000C, 32'd0, "ovr_absent_wr");
`endif
        pulse_done();
        // asynchronous reset from PEND
        rise();
        chk_irq(1'b1, "pre_reset_pend");
        rst_n = 1'b0;
        #1;
        expect_v(3, 32'd0, "async_rst_irq");
        expect_v(1, 32'h0001_0000, "async_rst_TH");
        expect_v(2, 32'd0, "async_rst_CON");
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_irq(1'b0, "post_reset_irq");
        rd(32'h4000_0008, 32'd0, "post_reset_TCON");
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
